// File: rtl/fifo_drain_stream_pkg.sv
// Shared types and constants for the FIFO drain stream stage.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } drain_state_e;

  localparam int SKID_DEPTH        = 2;
  localparam int DEFAULT_DATA_W    = 16;
  localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/fifo_drain_stream_skid_buf.sv
// Two-entry skid buffer that absorbs the one-cycle FIFO read latency.
// The head entry is always presented on head_data; occupancy counts 0..2.
module stream_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem0;
  logic [DATA_W-1:0] mem1;
  logic              wr_ptr;
  logic              rd_ptr;

  assign head_data = rd_ptr ? mem1 : mem0;

  // Ping-pong storage; a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0      <= '0;
      mem1      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_stream.sv
// Read-side drain stage: pops words from a 1-cycle-latency FIFO and presents them
// as a valid/ready stream grouped into bursts of BURST_LEN words marked by m_last.
// Optional transfer statistics are built when FIFO_DRAIN_STATS_EN is defined;
// otherwise stat_words/stat_bursts read as zero.
module fifo_drain_stream
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  input  logic              fifo_underflow,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_underflow,
  output logic [31:0]       stat_words,
  output logic [15:0]       stat_bursts
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  drain_state_e      state;
  logic              inflight;
  logic [BEAT_W-1:0] beat;
  logic [1:0]        occupancy;
  logic              xfer;
  logic [2:0]        credit_used;

  stream_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_data_out),
    .pop      (xfer),
    .head_data(m_data),
    .occupancy(occupancy)
  );

  assign m_valid = (occupancy != 2'd0);
  assign xfer    = m_valid & m_ready;

  // A word leaving the skid this cycle frees its slot immediately, which is what
  // keeps back-to-back transfers free of bubbles.
  assign credit_used = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, xfer};
  assign fifo_rd_en  = (state == RUN) & ~fifo_empty & (credit_used < 3'(SKID_DEPTH));

  // The final word of a stop-drain closes a truncated burst early.
  assign m_last = m_valid &
                  ((beat == LAST_BEAT) |
                   ((state == STOP) & (occupancy == 2'd1) & ~inflight));

  // Run/stop control; busy is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!drain_en) state <= STOP;
        end
        STOP: begin
          if (drain_en) begin
            state <= RUN;
          end else if (!inflight && occupancy == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tracks the read issued last cycle whose data lands in the skid this cycle.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  // Position within the current burst, restarting after every m_last transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (xfer) begin
      beat <= m_last ? '0 : beat + BEAT_W'(1);
    end
  end

  // Sticky underflow indication, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                 err_underflow <= 1'b0;
    else if (fifo_underflow) err_underflow <= 1'b1;
  end

`ifdef FIFO_DRAIN_STATS_EN
  // Free-running transfer and burst counters, wrapping at their widths.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words  <= '0;
      stat_bursts <= '0;
    end else if (xfer) begin
      stat_words <= stat_words + 32'd1;
      if (m_last) stat_bursts <= stat_bursts + 16'd1;
    end
  end
`else
  assign stat_words  = '0;
  assign stat_bursts = '0;
`endif

endmodule
